// File: rtl/minicpu_fetch_decode.sv
// Instruction fetch/decode front end for MiniCPU: loadable instruction memory, PC sequencing, valid/ready issue.
// Optional JMP support (opcode 3'b110) is compiled in when MINICPU_FETCH_JMP_EN is defined.
module minicpu_fetch_decode #(
    parameter int unsigned IMEM_DEPTH = 16,
    parameter int unsigned PC_W       = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            prog_we,
    input  logic [PC_W-1:0] prog_addr,
    input  logic [12:0]     prog_data,
    input  logic            start,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [2:0]      opcode,
    output logic [1:0]      wr_addr,
    output logic [1:0]      rd_addr1,
    output logic [1:0]      rd_addr2,
    output logic [3:0]      wr_data,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            done
);

    localparam int unsigned INSTR_W = 13;
    localparam logic [2:0]  OP_HALT = 3'b111;
`ifdef MINICPU_FETCH_JMP_EN
    localparam logic [2:0]  OP_JMP  = 3'b110;
`endif

    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] wr_addr;
        logic [1:0] rd_addr1;
        logic [1:0] rd_addr2;
        logic [3:0] wr_data;
    } instr_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALTED
    } state_t;

    state_t             state;
    logic [INSTR_W-1:0] imem [IMEM_DEPTH];
    instr_t             fetched_c;
    logic               prog_en_c;
    logic               issuable_c;

    assign fetched_c = instr_t'(imem[pc]);
    assign prog_en_c = prog_we && ((state == S_IDLE) || (state == S_HALTED));

    // Words consumed inside the front end (HALT, and JMP when enabled) never raise out_valid.
`ifdef MINICPU_FETCH_JMP_EN
    assign issuable_c = (fetched_c.opcode != OP_HALT) && (fetched_c.opcode != OP_JMP);
`else
    assign issuable_c = (fetched_c.opcode != OP_HALT);
`endif

    // Program memory: no reset, writable only while the sequencer is parked.
    always_ff @(posedge clk) begin
        if (prog_en_c) begin
            imem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            opcode    <= 3'b0;
            wr_addr   <= 2'b0;
            rd_addr1  <= 2'b0;
            rd_addr2  <= 2'b0;
            wr_data   <= 4'b0;
            pc        <= PC_W'(0);
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        pc    <= PC_W'(0);
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    opcode    <= fetched_c.opcode;
                    wr_addr   <= fetched_c.wr_addr;
                    rd_addr1  <= fetched_c.rd_addr1;
                    rd_addr2  <= fetched_c.rd_addr2;
                    wr_data   <= fetched_c.wr_data;
                    out_valid <= issuable_c;
                    state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (opcode == OP_HALT) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_HALTED;
`ifdef MINICPU_FETCH_JMP_EN
                    end else if (opcode == OP_JMP) begin
                        pc    <= PC_W'(wr_data);
                        state <= S_FETCH;
`endif
                    end else if (out_valid && out_ready) begin
                        // Depth is a power of two, so the natural overflow wraps to 0.
                        out_valid <= 1'b0;
                        pc        <= pc + PC_W'(1);
                        state     <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minicpu_fetch_decode.sv
// Directed bench for minicpu_fetch_decode: scoreboard of expected issues plus cycle-level checks.
// Covers MINICPU_FETCH_JMP_EN in both settings.
module tb_minicpu_fetch_decode;

    typedef struct packed {
        logic [3:0]  pc;
        logic [12:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [12:0] prog_data = '0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [2:0]  opcode;
    logic [1:0]  wr_addr, rd_addr1, rd_addr2;
    logic [3:0]  wr_data;
    logic [3:0]  pc;
    logic        busy, done;

    logic        w_prog_we = 1'b0;
    logic [1:0]  w_prog_addr = '0;
    logic [12:0] w_prog_data = '0;
    logic        w_start = 1'b0;
    logic        w_out_ready = 1'b0;
    logic        w_out_valid;
    logic [2:0]  w_opcode;
    logic [1:0]  w_wr_addr, w_rd_addr1, w_rd_addr2;
    logic [3:0]  w_wr_data;
    logic [1:0]  w_pc;
    logic        w_busy, w_done;

    int   n_checks = 0;
    int   n_fail = 0;
    int   n_xfer = 0;
    int   w_xfer = 0;
    exp_t sb[$];
    exp_t wsb[$];
    exp_t mon_e;
    exp_t wmon_e;

    localparam logic [12:0] W0  = 13'b000_00_00_01_1010;
    localparam logic [12:0] W1  = 13'b000_01_00_01_0101;
    localparam logic [12:0] W2  = 13'b001_11_00_01_0000;
    localparam logic [12:0] W3  = 13'b111_00_00_00_0000;
    localparam logic [12:0] WN  = 13'b010_10_11_00_0110;
    localparam logic [12:0] W0B = 13'b011_01_10_11_1100;
    localparam logic [12:0] WJ  = 13'b110_00_00_00_0011;

    always #5 clk = ~clk;

    minicpu_fetch_decode #(.IMEM_DEPTH(16), .PC_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .out_ready(out_ready),
        .out_valid(out_valid), .opcode(opcode), .wr_addr(wr_addr),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .wr_data(wr_data),
        .pc(pc), .busy(busy), .done(done)
    );

    minicpu_fetch_decode #(.IMEM_DEPTH(4), .PC_W(2)) u_wrap (
        .clk(clk), .rst_n(rst_n), .prog_we(w_prog_we), .prog_addr(w_prog_addr),
        .prog_data(w_prog_data), .start(w_start), .out_ready(w_out_ready),
        .out_valid(w_out_valid), .opcode(w_opcode), .wr_addr(w_wr_addr),
        .rd_addr1(w_rd_addr1), .rd_addr2(w_rd_addr2), .wr_data(w_wr_data),
        .pc(w_pc), .busy(w_busy), .done(w_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic prog(input logic [3:0] a, input logic [12:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick(1);
        prog_we = 1'b0;
    endtask

    task automatic push(input logic [3:0] p, input logic [12:0] d);
        sb.push_back({p, d});
    endtask

    task automatic wait_done(input string tag, input int lim);
        int i = 0;
        while (!done && i < lim) begin
            tick(1);
            i++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    // Transfers are sampled on the falling edge, before the rising edge that completes them.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_xfer++;
            n_checks++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_xfer: observed pc %0d expected no transfer", pc);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                n_checks++;
                assert ({pc, opcode, wr_addr, rd_addr1, rd_addr2, wr_data} === mon_e) else begin
                    n_fail++;
                    $error("FAIL xfer_fields: observed %0h expected %0h",
                           {pc, opcode, wr_addr, rd_addr1, rd_addr2, wr_data}, mon_e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && w_out_valid && w_out_ready) begin
            w_xfer++;
            n_checks++;
            assert (wsb.size() != 0) else begin
                n_fail++;
                $error("FAIL wrap_unexpected_xfer: observed pc %0d expected no transfer", w_pc);
            end
            if (wsb.size() != 0) begin
                wmon_e = wsb.pop_front();
                n_checks++;
                assert ({2'b00, w_pc, w_opcode, w_wr_addr, w_rd_addr1, w_rd_addr2, w_wr_data} === wmon_e) else begin
                    n_fail++;
                    $error("FAIL wrap_fields: observed %0h expected %0h",
                           {2'b00, w_pc, w_opcode, w_wr_addr, w_rd_addr1, w_rd_addr2, w_wr_data}, wmon_e);
                end
            end
        end
    end

    initial begin
        // Reset values
        tick(2);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Basic issue with exact 2-cycle cadence
        prog(4'd0, W0); prog(4'd1, W1); prog(4'd2, W2); prog(4'd3, W3);
        push(4'd0, W0); push(4'd1, W1); push(4'd2, W2);
        out_ready = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("fetch_valid", 32'(out_valid), 32'd0);
        check("fetch_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check("issue_valid", 32'(out_valid), 32'd1);
            check("issue_pc", 32'(pc), 32'(k));
            tick(1);
            check("gap_valid", 32'(out_valid), 32'd0);
        end
        tick(1);
        check("halt_issue_valid", 32'(out_valid), 32'd0);
        check("halt_issue_done", 32'(done), 32'd0);
        tick(1);
        check("halted_done", 32'(done), 32'd1);
        check("halted_busy", 32'(busy), 32'd0);
        check("halted_pc", 32'(pc), 32'd3);
        tick(3);
        check("basic_xfers", 32'(n_xfer), 32'd3);
        check("basic_sb_empty", 32'(sb.size()), 32'd0);

        // Backpressure, with prog_we and start ignored during ISSUE
        out_ready = 1'b0;
        push(4'd0, W0); push(4'd1, W1); push(4'd2, W2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("restart_done_clr", 32'(done), 32'd0);
        tick(1);
        for (int k = 0; k < 5; k++) begin
            prog_we = 1'b1; prog_addr = 4'd1; prog_data = WN; start = 1'b1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_pc", 32'(pc), 32'd0);
            check("bp_fields", 32'({opcode, wr_addr, rd_addr1, rd_addr2, wr_data}), 32'(W0));
            tick(1);
        end
        prog_we = 1'b0; start = 1'b0;
        check("bp_xfers_held", 32'(n_xfer), 32'd3);
        out_ready = 1'b1;
        tick(1);
        check("bp_one_xfer", 32'(n_xfer), 32'd4);
        wait_done("bp_wait_done", 40);
        check("bp_xfers", 32'(n_xfer), 32'd6);

        // Writes in HALTED take effect, including one coincident with start at address 0
        prog(4'd1, WN);
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = W0B; start = 1'b1;
        push(4'd0, W0B); push(4'd1, WN); push(4'd2, W2);
        tick(1);
        prog_we = 1'b0; start = 1'b0;
        wait_done("halted_wr_wait_done", 40);
        check("halted_wr_xfers", 32'(n_xfer), 32'd9);

        // Asynchronous reset during ISSUE
        out_ready = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_pc", 32'(pc), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(4);
        check("post_rst_idle_busy", 32'(busy), 32'd0);
        check("post_rst_idle_valid", 32'(out_valid), 32'd0);

        // Opcode 3'b110: JMP when enabled, ordinary instruction otherwise
        prog(4'd0, WJ);
        out_ready = 1'b1;
`ifndef MINICPU_FETCH_JMP_EN
        push(4'd0, WJ); push(4'd1, WN); push(4'd2, W2);
`endif
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done("op110_wait_done", 40);
        check("op110_pc", 32'(pc), 32'd3);
`ifdef MINICPU_FETCH_JMP_EN
        check("jmp_xfers", 32'(n_xfer), 32'd9);
`else
        check("op110_xfers", 32'(n_xfer), 32'd12);
`endif
        check("op110_sb_empty", 32'(sb.size()), 32'd0);

        // Wrap-around on a 4-deep instance with no HALT
        for (int a = 0; a < 4; a++) begin
            w_prog_we = 1'b1; w_prog_addr = 2'(a); w_prog_data = {3'(a), 10'(a * 37 + 5)};
            tick(1);
        end
        w_prog_we = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wsb.push_back({4'(k % 4), 3'(k % 4), 10'((k % 4) * 37 + 5)});
        end
        w_out_ready = 1'b1;
        w_start = 1'b1;
        tick(1);
        w_start = 1'b0;
        for (int i = 0; i < 40 && w_xfer < 5; i++) tick(1);
        w_out_ready = 1'b0;
        check("wrap_xfers", 32'(w_xfer), 32'd5);
        tick(1);
        check("wrap_next_pc", 32'(w_pc), 32'd1);
        check("wrap_valid_held", 32'(w_out_valid), 32'd1);
        check("wrap_sb_empty", 32'(wsb.size()), 32'd0);
        check("wrap_done", 32'(w_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
